// File: rtl/fetch_unit_pkg.sv
// Fetch unit shared types and constants.
// States, JALR opcode, queue entry layout, default sizes.
package fetch_unit_pkg;

  localparam int CACHE_LINES_DEF = 256;
  localparam int LINE_WORDS_DEF  = 4;
  localparam int IQ_DEPTH_DEF    = 4;

  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [1:0] {
    S_FETCH,
    S_REFILL,
    S_STALL
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        isjp;
  } iq_entry_t;

  localparam int IQ_ENTRY_W = $bits(iq_entry_t);

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: memory controller, predictor,
// redirect and instruction-queue signals.
interface fetch_unit_if;

  logic        mctr_ok;
  logic [31:0] mctr_data;
  logic        mctr_ready;
  logic [31:0] mctr_addr;

  logic [31:0] pred_pc;
  logic [31:0] pred_ins;
  logic [31:0] pred_npc;
  logic        pred_isjp;

  logic        jalr_ok;
  logic [31:0] jalr_pc;
  logic        rob_set;
  logic [31:0] rob_pc;

  logic        iq_pop;
  logic        iq_valid;
  logic [31:0] iq_data;
  logic [31:0] iq_pc;
  logic        iq_isjp;

  modport master (
    input  mctr_ok, mctr_data,
    input  pred_npc, pred_isjp,
    input  jalr_ok, jalr_pc,
    input  rob_set, rob_pc,
    input  iq_pop,
    output mctr_ready, mctr_addr,
    output pred_pc, pred_ins,
    output iq_valid, iq_data,
    output iq_pc, iq_isjp
  );

  modport slave (
    output mctr_ok, mctr_data,
    output pred_npc, pred_isjp,
    output jalr_ok, jalr_pc,
    output rob_set, rob_pc,
    output iq_pop,
    input  mctr_ready, mctr_addr,
    input  pred_pc, pred_ins,
    input  iq_valid, iq_data,
    input  iq_pc, iq_isjp
  );

endinterface

// File: rtl/fetch_iqueue.sv
// Circular instruction queue with flush.
// Head reads as zero while the queue is empty.
module fetch_iqueue #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic         full,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign valid = (cnt_q != '0);
  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign head  = valid ? mem_q[rd_q] : '0;

  // Pointer/count update; a pop on an empty queue is dropped.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    do_pop  = pop && valid && !flush;
    do_push = push && !flush && (!full || do_pop);
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + (PW+1)'(do_push)
                    - (PW+1)'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage, not reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: direct-mapped I-cache, refill
// FSM, JALR stall and ROB redirect into a queue.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int CACHE_LINES = CACHE_LINES_DEF,
  parameter int LINE_WORDS  = LINE_WORDS_DEF,
  parameter int IQ_DEPTH    = IQ_DEPTH_DEF
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int OFF_B = (OFF_W > 0) ? OFF_W : 1;
  localparam int IDX_W = $clog2(CACHE_LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [31:0] LMASK =
    32'(LINE_WORDS * 4 - 1);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  maddr_q, maddr_d;
  logic         mrdy_q, mrdy_d;
  logic [OFF_B-1:0] cnt_q, cnt_d;
  logic [CACHE_LINES-1:0] valid_q, valid_d;

  logic [TAG_W-1:0] tag_mem [CACHE_LINES];
  logic [31:0] data_mem [CACHE_LINES][LINE_WORDS];

  logic [OFF_B-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [31:0]      ins;
  logic             hit;
  logic             iq_full;
  logic             push;
  logic             wr_en;
  logic             last;
  iq_entry_t        in_e, head_e;

  if (OFF_W > 0) begin : g_off
    assign off = pc_q[2 +: OFF_B];
  end else begin : g_nooff
    assign off = '0;
  end

  assign idx = pc_q[2+OFF_W +: IDX_W];
  assign tag = pc_q[31 -: TAG_W];
  assign ins = data_mem[idx][off];
  assign hit = valid_q[idx]
            && (tag_mem[idx] == tag);

  assign push = (state_q == S_FETCH) && hit
             && !bus.rob_set
             && (!iq_full || bus.iq_pop);

  assign last  = (cnt_q == OFF_B'(LINE_WORDS - 1));
  assign wr_en = (state_q == S_REFILL) && mrdy_q
              && bus.mctr_ok && !bus.rob_set;

  assign bus.pred_pc    = pc_q;
  assign bus.pred_ins   = ins;
  assign bus.mctr_ready = mrdy_q;
  assign bus.mctr_addr  = maddr_q;

  assign in_e = '{ins: ins, pc: pc_q,
                  isjp: bus.pred_isjp};

  assign bus.iq_data = head_e.ins;
  assign bus.iq_pc   = head_e.pc;
  assign bus.iq_isjp = head_e.isjp;

  fetch_iqueue #(
    .DEPTH (IQ_DEPTH),
    .W     (IQ_ENTRY_W)
  ) u_iq (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.rob_set),
    .push      (push),
    .push_data (in_e),
    .pop       (bus.iq_pop),
    .valid     (bus.iq_valid),
    .full      (iq_full),
    .head      (head_e)
  );

  // Next state: redirect first, then per-state work.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    maddr_d = maddr_q;
    mrdy_d  = mrdy_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (bus.rob_set) begin
      pc_d    = bus.rob_pc;
      state_d = S_FETCH;
      mrdy_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (!hit) begin
            valid_d[idx] = 1'b0;
            state_d      = S_REFILL;
            mrdy_d       = 1'b1;
            maddr_d      = pc_q & ~LMASK;
            cnt_d        = '0;
          end else if (push) begin
            pc_d = bus.pred_npc;
            if (ins[6:0] == OP_JALR)
              state_d = S_STALL;
          end
        end
        S_REFILL: begin
          if (bus.mctr_ok) begin
            maddr_d = maddr_q + 32'd4;
            cnt_d   = cnt_q + OFF_B'(1);
            if (last) begin
              valid_d[idx] = 1'b1;
              mrdy_d       = 1'b0;
              state_d      = S_FETCH;
            end
          end
        end
        S_STALL: begin
          if (bus.jalr_ok) begin
            pc_d    = bus.jalr_pc;
            state_d = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      maddr_q <= '0;
      mrdy_q  <= 1'b0;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      maddr_q <= maddr_d;
      mrdy_q  <= mrdy_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // Cache data and tags; valid bits alone gate hits.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[idx][cnt_q] <= bus.mctr_data;
      if (last) tag_mem[idx] <= tag;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table-driven cold
// miss/queue sweep plus stall, redirect, evict, reset.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(
    .CACHE_LINES (64),
    .LINE_WORDS  (4),
    .IQ_DEPTH    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.pred_npc = bus.pred_pc + 32'd4;

  typedef struct {
    logic        pop;
    logic        rdy;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] iqpc;
    logic [31:0] ppc;
  } vec_t;

  vec_t vecs [26];
  int   total = 0;
  int   bad   = 0;
  bit   auto_mem = 1'b1;
  bit   jalr8 = 1'b0;
  bit   found;

  function automatic logic [31:0] mem_word(
    input logic [31:0] a);
    if (jalr8 && a == 32'h8) return 32'h000080E7;
    return {a[23:0], 8'h13};
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    if (auto_mem) begin
      bus.mctr_ok   = bus.mctr_ready;
      bus.mctr_data = mem_word(bus.mctr_addr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.iq_pop  = 1'b0;
    bus.rob_set = 1'b0;
    bus.jalr_ok = 1'b0;
    bus.mctr_ok = 1'b0;
    auto_mem    = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] t);
    bus.rob_set = 1'b1;
    bus.rob_pc  = t;
    tick();
    bus.rob_set = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{0, 1, 32'h00, 0, 32'h00, 32'h00};
    vecs[1]  = '{0, 1, 32'h04, 0, 32'h00, 32'h00};
    vecs[2]  = '{0, 1, 32'h08, 0, 32'h00, 32'h00};
    vecs[3]  = '{0, 1, 32'h0C, 0, 32'h00, 32'h00};
    vecs[4]  = '{0, 0, 32'h00, 0, 32'h00, 32'h00};
    vecs[5]  = '{0, 0, 32'h00, 1, 32'h00, 32'h04};
    vecs[6]  = '{0, 0, 32'h00, 1, 32'h00, 32'h08};
    vecs[7]  = '{0, 0, 32'h00, 1, 32'h00, 32'h0C};
    vecs[8]  = '{0, 0, 32'h00, 1, 32'h00, 32'h10};
    vecs[9]  = '{0, 1, 32'h10, 1, 32'h00, 32'h10};
    vecs[10] = '{0, 1, 32'h14, 1, 32'h00, 32'h10};
    vecs[11] = '{0, 1, 32'h18, 1, 32'h00, 32'h10};
    vecs[12] = '{0, 1, 32'h1C, 1, 32'h00, 32'h10};
    vecs[13] = '{0, 0, 32'h00, 1, 32'h00, 32'h10};
    vecs[14] = '{0, 0, 32'h00, 1, 32'h00, 32'h10};
    vecs[15] = '{0, 0, 32'h00, 1, 32'h00, 32'h10};
    vecs[16] = '{1, 0, 32'h00, 1, 32'h04, 32'h14};
    vecs[17] = '{1, 0, 32'h00, 1, 32'h08, 32'h18};
    vecs[18] = '{1, 0, 32'h00, 1, 32'h0C, 32'h1C};
    vecs[19] = '{1, 0, 32'h00, 1, 32'h10, 32'h20};
    vecs[20] = '{1, 1, 32'h20, 1, 32'h14, 32'h20};
    vecs[21] = '{1, 1, 32'h24, 1, 32'h18, 32'h20};
    vecs[22] = '{1, 1, 32'h28, 1, 32'h1C, 32'h20};
    vecs[23] = '{1, 1, 32'h2C, 0, 32'h00, 32'h20};
    vecs[24] = '{1, 0, 32'h00, 0, 32'h00, 32'h20};
    vecs[25] = '{0, 0, 32'h00, 1, 32'h20, 32'h24};

    bus.mctr_ok   = 1'b0;
    bus.mctr_data = '0;
    bus.pred_isjp = 1'b0;
    bus.jalr_ok   = 1'b0;
    bus.jalr_pc   = '0;
    bus.rob_set   = 1'b0;
    bus.rob_pc    = '0;
    bus.iq_pop    = 1'b0;

    // reset state, before any clock edge
    #2;
    check("rst_rdy", 32'(bus.mctr_ready), 0);
    check("rst_addr", bus.mctr_addr, 0);
    check("rst_vld", 32'(bus.iq_valid), 0);
    check("rst_data", bus.iq_data, 0);
    check("rst_iqpc", bus.iq_pc, 0);
    check("rst_isjp", 32'(bus.iq_isjp), 0);
    check("rst_pc", bus.pred_pc, 0);

    // cold miss, fill, full hold, pop/push sweep
    do_reset();
    for (int i = 0; i < 26; i++) begin
      bus.iq_pop = vecs[i].pop;
      tick();
      check($sformatf("v%0d_rdy", i),
            32'(bus.mctr_ready), 32'(vecs[i].rdy));
      if (vecs[i].rdy)
        check($sformatf("v%0d_addr", i),
              bus.mctr_addr, vecs[i].addr);
      check($sformatf("v%0d_vld", i),
            32'(bus.iq_valid), 32'(vecs[i].vld));
      check($sformatf("v%0d_iqpc", i),
            bus.iq_pc, vecs[i].iqpc);
      check($sformatf("v%0d_data", i), bus.iq_data,
            vecs[i].vld ? mem_word(vecs[i].iqpc) : 0);
      check($sformatf("v%0d_ppc", i),
            bus.pred_pc, vecs[i].ppc);
    end
    bus.iq_pop = 1'b0;

    // JALR at 0x8 stalls until jalr_ok
    jalr8 = 1'b1;
    do_reset();
    bus.iq_pop = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.iq_valid && bus.iq_pc == 32'h8) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("jalr_seen", 32'(found), 1);
    check("jalr_word", bus.iq_data, 32'h000080E7);
    tick();
    tick();
    tick();
    check("stall_vld", 32'(bus.iq_valid), 0);
    check("stall_pc", bus.pred_pc, 32'hC);
    check("stall_rdy", 32'(bus.mctr_ready), 0);
    bus.jalr_ok = 1'b1;
    bus.jalr_pc = 32'h100;
    tick();
    bus.jalr_ok = 1'b0;
    check("jalr_pc", bus.pred_pc, 32'h100);
    tick();
    check("jalr_rdy", 32'(bus.mctr_ready), 1);
    check("jalr_addr", bus.mctr_addr, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.iq_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("jalr_resume", 32'(found), 1);
    check("jalr_iqpc", bus.iq_pc, 32'h100);
    bus.iq_pop = 1'b0;
    jalr8 = 1'b0;

    // redirect in the middle of a refill
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.mctr_ready && bus.mctr_addr == 32'h10)
      begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("rob_pre", 32'(found), 1);
    check("rob_pre_vld", 32'(bus.iq_valid), 1);
    auto_mem = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.mctr_ok   = 1'b1;
      bus.mctr_data = mem_word(bus.mctr_addr);
      tick();
    end
    bus.mctr_ok = 1'b0;
    redirect(32'h200);
    check("rob_rdy", 32'(bus.mctr_ready), 0);
    check("rob_vld", 32'(bus.iq_valid), 0);
    check("rob_pc", bus.pred_pc, 32'h200);
    bus.mctr_ok   = 1'b1;
    bus.mctr_data = 32'hDEAD_BEEF;
    tick();
    bus.mctr_ok = 1'b0;
    check("rob_rf_rdy", 32'(bus.mctr_ready), 1);
    check("rob_rf_addr", bus.mctr_addr, 32'h200);
    auto_mem = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.iq_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("rob_fill", 32'(found), 1);
    check("rob_iqpc", bus.iq_pc, 32'h200);
    check("rob_iqdata", bus.iq_data,
          mem_word(32'h200));
    redirect(32'h10);
    check("part_pc", bus.pred_pc, 32'h10);
    tick();
    check("part_rdy", 32'(bus.mctr_ready), 1);
    check("part_addr", bus.mctr_addr, 32'h10);
    redirect(32'h0);
    tick();
    check("l0_hit_rdy", 32'(bus.mctr_ready), 0);
    check("l0_hit_vld", 32'(bus.iq_valid), 1);
    check("l0_hit_pc", bus.iq_pc, 32'h0);

    // same-index conflict evicts line 0
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.iq_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("ev_fill0", 32'(found), 1);
    redirect(32'h400);
    tick();
    check("ev_rdy", 32'(bus.mctr_ready), 1);
    check("ev_addr", bus.mctr_addr, 32'h400);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.iq_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("ev_fill", 32'(found), 1);
    check("ev_iqpc", bus.iq_pc, 32'h400);
    check("ev_data", bus.iq_data, mem_word(32'h400));
    redirect(32'h0);
    check("ev_back_pc", bus.pred_pc, 32'h0);
    tick();
    check("ev_re_rdy", 32'(bus.mctr_ready), 1);
    check("ev_re_addr", bus.mctr_addr, 32'h0);

    // asynchronous reset between edges mid-refill
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.mctr_ready && bus.mctr_addr == 32'h10)
      begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("ar_pre", 32'(found), 1);
    check("ar_pre_vld", 32'(bus.iq_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_rdy", 32'(bus.mctr_ready), 0);
    check("ar_vld", 32'(bus.iq_valid), 0);
    check("ar_addr", bus.mctr_addr, 0);
    check("ar_pc", bus.pred_pc, 0);
    check("ar_iqpc", bus.iq_pc, 0);
    rst = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
